// File: rtl/pipe_datapath_pkg.sv
// Shared definitions for the two-stage 9-bit-ISA datapath: ALU encodings,
// instruction field positions and elaboration helpers.
package pipe_datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SHL   = 3'd5,
    ALU_SHR   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

  localparam int IW     = 9;
  localparam int OPC_HI = 8;
  localparam int OPC_LO = 5;
  localparam int RA_HI  = 4;
  localparam int RA_LO  = 3;
  localparam int RB_HI  = 2;
  localparam int RB_LO  = 1;
  localparam int IMM_HI = 2;
  localparam int IMM_LO = 0;
  localparam int LUT_HI = 4;
  localparam int LUT_LO = 1;
  localparam int FC_BIT = 0;

  // Program counter value after reset.
  localparam int REG_PC = 0;

  // The 2-bit ra/rb fields address exactly four registers.
  localparam int ISA_NREG = 4;

  function automatic bit nreg_ok(input int n);
    return n == ISA_NREG;
  endfunction

endpackage

// File: rtl/pipe_alu.sv
// Combinational DW-wide ALU; shifts pull their fill bit from the stored carry flag.
module pipe_alu
  import pipe_datapath_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  alu_op_e       op_i,
  input  logic          c_in_i,
  input  logic          c_flag_i,
  output logic [DW-1:0] res_o,
  output logic          zero_o,
  output logic          carry_o
);

  logic [DW:0] sum;

  always_comb begin
    sum     = '0;
    res_o   = '0;
    carry_o = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        sum     = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, c_in_i};
        res_o   = sum[DW-1:0];
        carry_o = sum[DW];
      end
      ALU_SUB: begin
        // sum[DW] is the borrow; carry reports its absence.
        sum     = {1'b0, a_i} - {1'b0, b_i};
        res_o   = sum[DW-1:0];
        carry_o = ~sum[DW];
      end
      ALU_AND:   res_o = a_i & b_i;
      ALU_OR:    res_o = a_i | b_i;
      ALU_XOR:   res_o = a_i ^ b_i;
      ALU_SHL: begin
        res_o   = {a_i[DW-2:0], c_flag_i};
        carry_o = a_i[DW-1];
      end
      ALU_SHR: begin
        res_o   = {c_flag_i, a_i[DW-1:1]};
        carry_o = a_i[0];
      end
      ALU_PASSB: res_o = b_i;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage fetch/execute datapath for the 9-bit ISA with an external decoder,
// external branch LUT and a req/ack data memory port with timeout.
module pipe_datapath
  import pipe_datapath_pkg::*;
#(
  parameter int DW          = 8,
  parameter int PCW         = 16,
  parameter int NREG        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           CLK,
  input  logic           START,
  output logic [PCW-1:0] instr_addr,
  input  logic [IW-1:0]  instr_in,
  output logic [3:0]     opcode,
  output logic           fcode,
  input  logic           CTRL_branch_rel_nz,
  input  logic           CTRL_branch_rel_z,
  input  logic           CTRL_branch_abs,
  input  logic           CTRL_reg_write_en,
  input  logic           CTRL_mem_to_reg,
  input  logic           CTRL_alu_src,
  input  logic           CTRL_alu_sc_in,
  input  logic           CTRL_read_mem,
  input  logic           CTRL_write_mem,
  input  logic           CTRL_halt,
  input  logic [2:0]     CTRL_alu_op,
  output logic [3:0]     lut_idx,
  input  logic [PCW-1:0] lut_rel,
  input  logic [PCW-1:0] lut_abs,
  output logic [DW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic           mem_req,
  output logic           mem_we,
  input  logic           mem_ack,
  output logic           DONE,
  output logic           ERR
);

  if (!nreg_ok(NREG)) begin : g_bad_nreg
    $error("pipe_datapath: NREG must be 4 for the 9-bit ISA");
  end
  if (DW < 4) begin : g_bad_dw
    $error("pipe_datapath: DW must be at least 4");
  end
  if (MEM_TIMEOUT < 1) begin : g_bad_tmo
    $error("pipe_datapath: MEM_TIMEOUT must be at least 1");
  end

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [PCW-1:0] pc_q, pc_d, pc_ex_q, pc_ex_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic           valid_q, valid_d;
  logic           zf_q, zf_d, cf_q, cf_d;
  logic           done_q, done_d, err_q, err_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [DW-1:0]  rf_q [NREG];
  logic [DW-1:0]  rf_d [NREG];

  logic [1:0]     ra, rb;
  logic [DW-1:0]  imm, op_b, alu_res;
  logic           alu_zero, alu_carry;
  logic           exec, mem_op, stall, tmo_hit, is_br, taken;
  logic [PCW-1:0] target;

  assign ra   = ir_q[RA_HI:RA_LO];
  assign rb   = ir_q[RB_HI:RB_LO];
  assign imm  = {{(DW-3){1'b0}}, ir_q[IMM_HI:IMM_LO]};
  assign op_b = CTRL_alu_src ? imm : rf_q[rb];

  // A bubble or a halted core ignores every decoder output.
  assign exec    = valid_q & ~done_q;
  assign mem_op  = exec & (CTRL_read_mem | CTRL_write_mem);
  assign stall   = mem_op & ~mem_ack;
  assign tmo_hit = stall & (tmo_q == TW'(MEM_TIMEOUT - 1));

  assign is_br  = CTRL_branch_abs | CTRL_branch_rel_z | CTRL_branch_rel_nz;
  assign taken  = exec & (CTRL_branch_abs | (CTRL_branch_rel_z & zf_q) |
                          (CTRL_branch_rel_nz & ~zf_q));
  assign target = CTRL_branch_abs ? lut_abs : pc_ex_q + lut_rel;

  pipe_alu #(.DW(DW)) u_alu (
    .a_i      (rf_q[ra]),
    .b_i      (op_b),
    .op_i     (alu_op_e'(CTRL_alu_op)),
    .c_in_i   (CTRL_alu_sc_in),
    .c_flag_i (cf_q),
    .res_o    (alu_res),
    .zero_o   (alu_zero),
    .carry_o  (alu_carry)
  );

  always_comb begin
    pc_d    = pc_q;
    pc_ex_d = pc_ex_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    done_d  = done_q;
    err_d   = err_q;
    tmo_d   = '0;
    rf_d    = rf_q;
    if (done_q) begin
      valid_d = 1'b0;
    end else if (stall) begin
      if (tmo_hit) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        valid_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      ir_d    = instr_in;
      pc_ex_d = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + 1'b1;
      if (taken) begin
        pc_d    = target;
        valid_d = 1'b0;
      end
      if (exec && CTRL_halt) done_d = 1'b1;
      if (exec && CTRL_reg_write_en) begin
        rf_d[ra] = CTRL_mem_to_reg ? mem_rdata : alu_res;
        if (!(CTRL_read_mem || CTRL_write_mem) && !is_br && !CTRL_halt) begin
          zf_d = alu_zero;
          cf_d = alu_carry;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (START) begin
      pc_q    <= PCW'(REG_PC);
      pc_ex_q <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      pc_ex_q <= pc_ex_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      rf_q    <= rf_d;
    end
  end

  assign instr_addr = pc_q;
  assign opcode     = ir_q[OPC_HI:OPC_LO];
  assign fcode      = ir_q[FC_BIT];
  assign lut_idx    = ir_q[LUT_HI:LUT_LO];
  assign mem_addr   = rf_q[rb];
  assign mem_wdata  = rf_q[ra];
  assign mem_req    = mem_op;
  assign mem_we     = mem_op & CTRL_write_mem;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench: small program ROM plus a local opcode decoder driving the CTRL inputs.
module tb_pipe_datapath;

  localparam int DW  = 8;
  localparam int PCW = 16;

  localparam logic [3:0] OP_ADDI = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_LDI = 4'd3,
                         OP_LD = 4'd4, OP_ST = 4'd5, OP_BZ = 4'd6, OP_BNZ = 4'd7,
                         OP_JA = 4'd8, OP_JANZ = 4'd9, OP_HALT = 4'd10, OP_NOP = 4'd15;

  logic           CLK = 1'b0, START = 1'b0;
  logic [PCW-1:0] instr_addr;
  logic [8:0]     instr_in;
  logic [3:0]     opcode, lut_idx;
  logic           fcode;
  logic           c_rnz, c_rz, c_abs, c_rwe, c_m2r, c_src, c_sc, c_rd, c_wr, c_halt;
  logic [2:0]     c_op;
  logic [PCW-1:0] lut_rel, lut_abs;
  logic [DW-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic           mem_req, mem_we, mem_ack, DONE, ERR;

  logic [8:0]     imem [64];
  logic [PCW-1:0] rel_tab [16];
  logic [PCW-1:0] abs_tab [16];
  int             n_cmp = 0, n_err = 0;

  always #5 CLK = ~CLK;

  assign instr_in = (instr_addr < 16'd64) ? imem[instr_addr[5:0]] : {OP_NOP, 5'd0};
  assign lut_rel  = rel_tab[lut_idx];
  assign lut_abs  = abs_tab[lut_idx];

  always_comb begin
    {c_rnz, c_rz, c_abs, c_rwe, c_m2r, c_src, c_sc, c_rd, c_wr, c_halt} = '0;
    c_op = 3'd0;
    case (opcode)
      OP_ADDI: begin c_rwe = 1'b1; c_src = 1'b1; c_op = 3'd0; end
      OP_ADD:  begin c_rwe = 1'b1; c_op = 3'd0; end
      OP_SUB:  begin c_rwe = 1'b1; c_op = 3'd1; end
      OP_LDI:  begin c_rwe = 1'b1; c_src = 1'b1; c_op = 3'd7; end
      OP_LD:   begin c_rwe = 1'b1; c_rd = 1'b1; c_m2r = 1'b1; end
      OP_ST:   c_wr = 1'b1;
      OP_BZ:   c_rz = 1'b1;
      OP_BNZ:  c_rnz = 1'b1;
      OP_JA:   c_abs = 1'b1;
      OP_JANZ: begin c_abs = 1'b1; c_rnz = 1'b1; end
      OP_HALT: c_halt = 1'b1;
      default: ;
    endcase
  end

  pipe_datapath #(.DW(DW), .PCW(PCW), .NREG(4), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .START(START), .instr_addr(instr_addr), .instr_in(instr_in),
    .opcode(opcode), .fcode(fcode),
    .CTRL_branch_rel_nz(c_rnz), .CTRL_branch_rel_z(c_rz), .CTRL_branch_abs(c_abs),
    .CTRL_reg_write_en(c_rwe), .CTRL_mem_to_reg(c_m2r), .CTRL_alu_src(c_src),
    .CTRL_alu_sc_in(c_sc), .CTRL_read_mem(c_rd), .CTRL_write_mem(c_wr),
    .CTRL_halt(c_halt), .CTRL_alu_op(c_op), .lut_idx(lut_idx),
    .lut_rel(lut_rel), .lut_abs(lut_abs), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .DONE(DONE), .ERR(ERR)
  );

  function automatic logic [8:0] ins(input logic [3:0] op, input logic [1:0] ra,
                                     input logic [2:0] lo);
    return {op, ra, lo};
  endfunction

  function automatic logic [8:0] br(input logic [3:0] op, input logic [3:0] idx);
    return {op, idx, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = {OP_NOP, 5'd0};
    for (int i = 0; i < 16; i++) begin
      rel_tab[i] = '0;
      abs_tab[i] = '0;
    end
  endtask

  task automatic do_reset();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    clear_prog();

    // Straight-line ADDI pair
    imem[0] = ins(OP_ADDI, 2'd1, 3'd5);
    imem[1] = ins(OP_ADDI, 2'd1, 3'd5);
    do_reset();
    chk("rst_pc", instr_addr, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    tick();
    chk("a_pc1", instr_addr, 1);
    chk("a_opc", opcode, OP_ADDI);
    tick();
    chk("a_pc2", instr_addr, 2);
    chk("a_r1_5", dut.rf_q[1], 8'd5);
    tick();
    chk("a_pc3", instr_addr, 3);
    chk("a_r1_10", dut.rf_q[1], 8'd10);
    chk("a_zf", dut.zf_q, 0);
    chk("a_cf", dut.cf_q, 0);

    // Wrap to zero, then rel_z back by 3 with one flushed instruction
    clear_prog();
    imem[0] = ins(OP_LDI, 2'd2, 3'd1);
    imem[1] = ins(OP_SUB, 2'd0, {2'd2, 1'b0});
    imem[2] = ins(OP_ADDI, 2'd0, 3'd1);
    imem[7] = br(OP_BZ, 4'd2);
    imem[8] = ins(OP_ADDI, 2'd3, 3'd7);
    rel_tab[2] = 16'hFFFD;
    do_reset();
    repeat (3) tick();
    chk("b_r0_ff", dut.rf_q[0], 8'hFF);
    chk("b_sub_cf", dut.cf_q, 0);
    tick();
    chk("b_r0_0", dut.rf_q[0], 8'h00);
    chk("b_zf", dut.zf_q, 1);
    chk("b_cf", dut.cf_q, 1);
    repeat (4) tick();
    chk("b_lutidx", lut_idx, 2);
    chk("b_pc8", instr_addr, 8);
    tick();
    chk("b_target", instr_addr, 4);
    tick();
    chk("b_flush_r3", dut.rf_q[3], 8'h00);
    chk("b_pc5", instr_addr, 5);

    // Load acked on its fourth request cycle
    clear_prog();
    imem[0] = ins(OP_LD, 2'd3, {2'd1, 1'b0});
    do_reset();
    mem_ack = 1'b1;
    #1;
    chk("c_req_idle", mem_req, 0);
    tick();
    mem_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1 && instr_addr == 16'd1) n++;
      tick();
    end
    chk("c_stall3", n, 3);
    chk("c_req4", mem_req, 1);
    chk("c_we", mem_we, 0);
    chk("c_r3_pre", dut.rf_q[3], 8'h00);
    mem_ack   = 1'b1;
    mem_rdata = 8'h5A;
    tick();
    mem_ack   = 1'b0;
    chk("c_r3", dut.rf_q[3], 8'h5A);
    chk("c_pc2", instr_addr, 2);
    chk("c_req_off", mem_req, 0);

    // Store never acked: timeout
    clear_prog();
    imem[0] = ins(OP_ST, 2'd1, 3'd0);
    do_reset();
    tick();
    chk("d_we", mem_we, 1);
    n = 0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      n++;
      tick();
    end
    chk("d_req_cycles", n, 15);
    chk("d_err", ERR, 1);
    chk("d_done", DONE, 1);
    repeat (3) tick();
    chk("d_pc_frozen", instr_addr, 1);
    chk("d_req_low", mem_req, 0);

    // abs and rel_nz together: abs wins
    clear_prog();
    imem[0]    = br(OP_JANZ, 4'd3);
    abs_tab[3] = 16'h0040;
    rel_tab[3] = 16'h0005;
    do_reset();
    chk("e_err_clr", ERR, 0);
    chk("e_done_clr", DONE, 0);
    repeat (2) tick();
    chk("e_abs", instr_addr, 16'h0040);

    // Halt at PC 9
    clear_prog();
    imem[0]  = ins(OP_LDI, 2'd1, 3'd3);
    imem[9]  = ins(OP_HALT, 2'd0, 3'd0);
    imem[10] = ins(OP_LDI, 2'd1, 3'd6);
    imem[11] = ins(OP_LDI, 2'd2, 3'd7);
    do_reset();
    repeat (10) tick();
    chk("f_done_pre", DONE, 0);
    tick();
    chk("f_done", DONE, 1);
    chk("f_pc11", instr_addr, 11);
    repeat (3) tick();
    chk("f_r1_kept", dut.rf_q[1], 8'd3);
    chk("f_r2_kept", dut.rf_q[2], 8'd0);
    chk("f_pc_frozen", instr_addr, 11);

    // START in the middle of a load
    clear_prog();
    imem[0] = ins(OP_LDI, 2'd2, 3'd4);
    imem[1] = ins(OP_LD, 2'd0, {2'd2, 1'b0});
    do_reset();
    chk("g_done_clr", DONE, 0);
    repeat (2) tick();
    chk("g_req", mem_req, 1);
    chk("g_addr", mem_addr, 8'd4);
    START = 1'b1;
    tick();
    chk("g_req_rst", mem_req, 0);
    chk("g_pc_rst", instr_addr, 0);
    chk("g_r2_rst", dut.rf_q[2], 8'd0);
    START = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_datapath.md
Name: pipe_datapath

Overview:
- Parametrised two-stage (fetch/execute) successor to the single-cycle 9-bit-ISA datapath.
- Data width and PC width are generic. Flags are kept internally.
- Branch targets come from an external LUT; taken branches flush the fetch stage.
- Data memory sits behind a req/ack handshake with stall and timeout. The control decoder stays external and is driven from the EX-stage opcode.

Parameters:
- DW, 8, data/register width (>=4)
- PCW, 16, program counter width
- NREG, 4, register count (fixed at 4 for the 9-bit ISA; elaboration error otherwise)
- MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ack before error

Ports:
- CLK  in  1  clock
- START  in  1  synchronous active-high reset
- instr_addr  out  PCW  fetch address (= PC)
- instr_in  in  9  instruction word for instr_addr, combinational
- opcode  out  4  EX instruction [8:5]
- fcode  out  1  EX instruction [0]
- CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem, CTRL_halt  in  1 each  decoder outputs for the EX instruction
- CTRL_alu_op  in  3  ALU operation
- lut_idx  out  4  branch LUT index = EX instr [4:1]
- lut_rel  in  PCW  signed PC offset for index
- lut_abs  in  PCW  absolute target for index
- mem_addr  out  DW  = R[rb]
- mem_wdata  out  DW  = R[ra]
- mem_rdata  in  DW  load data, valid with mem_ack
- mem_req  out  1  transaction request
- mem_we  out  1  1 = store
- mem_ack  in  1  completes transaction
- DONE  out  1  sticky halt
- ERR  out  1  sticky memory timeout

Behaviour:
- Reset (START at an edge): PC=0; EX valid=0; R0..R3=0; zero/carry flags=0; mem_req=0; DONE=0; ERR=0; timeout counter=0. Reset mid-transaction abandons it; mem_req is low from the first post-reset cycle.
- Fields of the EX instruction:
  - ra=[4:3], rb=[2:1]
  - imm = zero-extended [2:0]
  - opB = alu_src ? imm : R[rb]
- Fetch, when not stalled and not DONE: ir<=instr_in, pc_ex<=PC, valid<=1, PC<=PC+1 (wraps mod 2^PCW).
- Bubble (valid=0): all CTRL inputs are ignored. No register, flag, memory or PC-redirect effect.
- ALU (all results mod 2^DW):
  - 0 ADD A+B+C_IN, carry out
  - 1 SUB A-B, carry = no-borrow
  - 2 AND; 3 OR; 4 XOR
  - 5 SHL: shift-in = carry flag, carry = A[DW-1]
  - 6 SHR: shift-in = carry flag, carry = A[0]
  - 7 PASSB
- Flags: zero/carry update only on a valid non-memory instruction with reg_write_en. Flags are not written by branches, memory ops or halt.
- Write-back: R[ra] <= mem_to_reg ? mem_rdata : ALU result, in the completing cycle.
- Branches resolve in EX, one bubble when taken:
  - rel_z is taken when zero=1; rel_nz is taken when zero=0. Target = pc_ex + lut_rel (signed, wrapping).
  - abs is always taken. Target = lut_abs.
  - If several are asserted, priority is abs > rel_z > rel_nz.
  - Taken: PC<=target and valid<=0 (flush).
- Memory (read_mem or write_mem on a valid instruction):
  - mem_req=1 and mem_we=write_mem from the first EX cycle.
  - PC, ir and valid hold (stall) until the cycle mem_ack=1. A load writes R[ra] in that cycle.
  - The next instruction enters EX on the following edge.
  - Ack-in-first-cycle gives zero stall. A store's latency equals the ack latency.
  - mem_ack while mem_req=0 is ignored.
- Timeout: the counter increments each stalled cycle. When it reaches MEM_TIMEOUT with no ack: mem_req<=0, ERR<=1, DONE<=1.
- Halt: a valid instruction with CTRL_halt sets DONE next edge. Once DONE=1:
  - PC freezes and valid<=0.
  - No writes or memory requests occur.
  - Only START clears DONE.
- Read/write of the same register in the same instruction reads the old value.

Decomposition:
- Shared package (definitions) holds:
  - alu_op enum (ADD..PASSB)
  - ISA field positions
  - REG_PC constant
  - the NREG=4 check
- One sub-module: pipe_alu (combinational ALU, DW-generic, returns result/zero/carry).
- State machine, register file and flags stay in pipe_datapath.

Test Plan:
- Reset, then ADD R1=R1+imm5 twice with DW=8 -> R1=10, instr_addr 0,1,2,... one per cycle, zero=0, carry=0.
- R0=8'hFF, ADD imm 1 -> R0=0, zero=1, carry=1. Next rel_z with lut_rel=-3 at pc_ex=7 -> PC=4, one flushed instruction produces no write.
- Load with mem_ack delayed 3 cycles, mem_rdata=8'h5A -> mem_req high 4 cycles, PC held, R[ra]=8'h5A on the ack cycle, fetch resumes the next cycle.
- Store with ack never returned, MEM_TIMEOUT=15 -> mem_req drops after 15 stalled cycles, ERR=1, DONE=1, PC frozen.
- abs and rel_nz both asserted, lut_abs=16'h0040 -> PC=16'h0040.
- CTRL_halt on instruction at PC 9 -> DONE=1 next edge, no later register change. START mid-load -> mem_req=0, all state reset.
